// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: cycles the PLL, qualifies lock, then releases the SDRAM
// and system resets in order; lock loss, timeout or a soft request restart it.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned SDRAM_TO_SYS_CYCLES = 256,
  parameter int unsigned LOCK_TIMEOUT        = 65536,
  parameter int unsigned CNT_W               = 17
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sdram_reset_n,
  output logic       sys_reset_n,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_count,
  output logic [7:0] timeout_count
);

  localparam int unsigned IDX_PLL_RST   = 0;
  localparam int unsigned IDX_WAIT_LOCK = 1;
  localparam int unsigned IDX_STABLE    = 2;
  localparam int unsigned IDX_SDRAM_UP  = 3;
  localparam int unsigned IDX_RUN       = 4;

  typedef enum logic [4:0] {
    S_PLL_RST   = 5'b00001,
    S_WAIT_LOCK = 5'b00010,
    S_STABLE    = 5'b00100,
    S_SDRAM_UP  = 5'b01000,
    S_RUN       = 5'b10000
  } state_e;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SDRAM_LAST   = CNT_W'(SDRAM_TO_SYS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_meta_q, locked_s_q;
  logic [7:0]       lock_loss_q, timeout_q;
  logic             loss_inc, tmo_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= S_PLL_RST;
      cnt_q         <= '0;
      lock_loss_q   <= '0;
      timeout_q     <= '0;
    end else begin
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      if (loss_inc && (lock_loss_q != '1)) lock_loss_q <= lock_loss_q + 8'd1;
      if (tmo_inc && (timeout_q != '1))    timeout_q   <= timeout_q + 8'd1;
    end
  end

  // Soft request outranks lock loss, which outranks counter expiry.
  always_comb begin
    state_d  = state_q;
    loss_inc = 1'b0;
    tmo_inc  = 1'b0;
    if (soft_reset_req) begin
      state_d = S_PLL_RST;
    end else begin
      unique case (state_q)
        S_PLL_RST: begin
          if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_PLL_RST;
            tmo_inc = 1'b1;
          end
        end
        S_STABLE: begin
          if (!locked_s_q)                state_d = S_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST)  state_d = S_SDRAM_UP;
        end
        S_SDRAM_UP: begin
          if (!locked_s_q) begin
            state_d  = S_PLL_RST;
            loss_inc = 1'b1;
          end else if (cnt_q == SDRAM_LAST) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_d  = S_PLL_RST;
            loss_inc = 1'b1;
          end
        end
        default: state_d = S_PLL_RST;
      endcase
    end
    cnt_d = cnt_q + 1'b1;
    if (soft_reset_req || (state_d != state_q)) cnt_d = '0;
  end

  assign pll_rst         = state_q[IDX_PLL_RST];
  assign sdram_reset_n   = state_q[IDX_SDRAM_UP] | state_q[IDX_RUN];
  assign sys_reset_n     = state_q[IDX_RUN];
  assign lock_loss_count = lock_loss_q;
  assign timeout_count   = timeout_q;

  always_comb begin
    seq_state = 3'd0;
    unique case (state_q)
      S_PLL_RST:   seq_state = 3'd0;
      S_WAIT_LOCK: seq_state = 3'd1;
      S_STABLE:    seq_state = 3'd2;
      S_SDRAM_UP:  seq_state = 3'd3;
      S_RUN:       seq_state = 3'd4;
      default:     seq_state = 3'd0;
    endcase
  end

  logic unused_idx;
  assign unused_idx = state_q[IDX_WAIT_LOCK] ^ state_q[IDX_STABLE];

endmodule
